riscv_mem_ctrl: RTL and testbench
=================================

RISCV_MEM_CTRL -- requirements
Module: riscv_mem_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 ex_mem_rdy  input  1  an execute-stage memory request is valid.
REQ-005 ex_mem_ack  output  1  the controller accepts the request this cycle.
REQ-006 ex_mem_funct  input  `MEM_FUNCT_W  one-hot op: LB, LBU, LH, LHU, LW, SB, SH, SW or NOP.
REQ-007 ex_mem_addr  input  32  byte address (op1+op2 from the ALU).
REQ-008 ex_mem_data  input  32  store data; the low byte or halfword is significant.
REQ-009 ex_mem_rsd  input  5  load destination register.
REQ-010 data_bif_addr  output  32  word-aligned bus address.
REQ-011 data_bif_req, data_bif_rnw  output  1 each  bus request; 1 = read.
REQ-012 data_bif_wmask  output  4  byte-lane write enables.
REQ-013 data_bif_wdata  output  32  lane-replicated write data.
REQ-014 data_bif_rdata, data_bif_ack  input  32, 1  read data; transfer complete.
REQ-015 mem_wb_data, mem_wb_rsd, mem_wb_write  output  32, 5, 1  load writeback.
REQ-016 mem_misalign  output  1  one-cycle pulse flagging a misaligned access (see Configuration).

Function
REQ-017 The controller SHALL implement the states IDLE, BUS and WB.
REQ-018 ex_mem_ack SHALL equal (state==IDLE); a request is accepted on rdy&&ack.
REQ-019 An accepted NOP SHALL leave the state in IDLE and cause no bus or writeback activity.
REQ-020 On accepting a load or store, the controller SHALL register the op, addr, rsd and data, and go IDLE->BUS.
REQ-021 In BUS, data_bif_req SHALL be 1 and all data_bif_* outputs SHALL stay stable until data_bif_ack.
REQ-022 data_bif_addr SHALL be {addr[31:2],2'b00}.
REQ-023 data_bif_rnw SHALL be 1 for loads and 0 for stores.
REQ-024 wmask SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000.
REQ-025 wdata SHALL be: SB the byte replicated x4; SH the halfword replicated x2; SW the word.
REQ-026 On ack in BUS, a store SHALL go to IDLE and a load SHALL capture rdata and go to WB.
REQ-027 In WB, mem_wb_write SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-028 In WB, LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the lane selected by addr[1:0] (byte) or addr[1] (halfword).
REQ-029 Latency: accept at cycle N, req high from N+1; ack at M gives a load writeback at M+1 and IDLE at M+2; a store is in IDLE at M+1.
REQ-030 An ack arriving in the same cycle req first rises SHALL complete the transfer (minimum bus latency is 1 cycle).
REQ-031 data_bif_ack outside BUS SHALL be ignored.
REQ-032 An ex_mem_funct that is not one-hot, when accepted, SHALL be treated as NOP.

Reset
REQ-033 While rstn=0 the state SHALL be IDLE, and req, write, misalign and wmask SHALL be 0.
REQ-034 While rstn=0, addr, wdata, wb_data and wb_rsd SHALL be 0, and ex_mem_ack SHALL be 1 once rstn deasserts.
REQ-035 Reset asserted mid-BUS SHALL abandon the transfer: req drops immediately and any later ack is ignored.

Configuration
REQ-036 With RISCV_MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL pulse mem_misalign one cycle after accept, issue no bus access, and return to IDLE.
REQ-037 Without RISCV_MEM_MISALIGN_TRAP_EN: mem_misalign SHALL be tied 0 and the offending low address bits SHALL be treated as zero.

Structure
REQ-038 The `MEM_* one-hot codes and `MEM_FUNCT_W SHALL live in the shared riscv_defines header, alongside `EX_*.
REQ-039 Lane steering, masking and extension SHALL be one combinational sub-module, riscv_mem_lane.

Verification
REQ-040 SB at addr 0x103, data 0xA5 -> bus addr 0x100, wmask 4'b1000, wdata 0xA5A5A5A5, rnw=0, with no writeback.
REQ-041 LB at addr 0x102, rdata 0x00800000, rsd 7 -> wb_data 0xFFFFFF80 with rsd 7 for one cycle; LBU at the same address -> 0x00000080.
REQ-042 LH at addr 0x002, with ack delayed 5 cycles -> req held for 6 cycles with stable outputs, ex_mem_ack=0 throughout, then rdata 0x8001xxxx -> 0xFFFF8001.
REQ-043 Back-to-back SW 0x200/0xDEADBEEF then LW 0x200, with ack in the same cycle as req -> store done and next accept 2 cycles apart, and the load returns rdata.
REQ-044 With the macro defined, LW at addr 0x201 -> mem_misalign pulses once, req never rises, and the controller is back in IDLE at N+2.
REQ-045 rstn asserted while req=1 -> req drops asynchronously, and an ack after release yields no writeback.

Source files
------------

// File: rtl/riscv_mem_ctrl_pkg.sv
// riscv_mem_ctrl_pkg
// Types and helpers shared by the memory-stage controller and its lane unit.
//   mem_state_e    controller states (TRAP is used only when the
//                  RISCV_MEM_MISALIGN_TRAP_EN build option is defined)
//   mem_op_e       compact internal encoding of a memory operation
//   decode_funct   one-hot `MEM_* code -> mem_op_e (anything else -> OP_NOP)
//   is_load        true for the five load flavours
//   is_misaligned  true for a halfword/word access off its natural boundary
`include "riscv_defines.sv"

package riscv_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        WB,
        TRAP
    } mem_state_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_LB,
        OP_LBU,
        OP_LH,
        OP_LHU,
        OP_LW,
        OP_SB,
        OP_SH,
        OP_SW
    } mem_op_e;

    // Every listed code is one-hot, so a multi-hot or zero code falls
    // into the default branch and becomes a NOP.
    function automatic mem_op_e decode_funct(input logic [`MEM_FUNCT_W-1:0] funct);
        mem_op_e op;
        case (funct)
            `MEM_LB:  op = OP_LB;
            `MEM_LBU: op = OP_LBU;
            `MEM_LH:  op = OP_LH;
            `MEM_LHU: op = OP_LHU;
            `MEM_LW:  op = OP_LW;
            `MEM_SB:  op = OP_SB;
            `MEM_SH:  op = OP_SH;
            `MEM_SW:  op = OP_SW;
            default:  op = OP_NOP;
        endcase
        return op;
    endfunction

    function automatic logic is_load(input mem_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = addr_lo[0];
            OP_LW, OP_SW:         mis = (addr_lo != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_defines.sv
// riscv_defines
// Shared opcode definitions for the execute and memory stages of the core.
// All encodings are one-hot. A code that is not one of these values is
// treated by the consumer as a NOP.
//   `EX_FUNCT_W  / `EX_*   execute-stage ALU operation codes
//   `MEM_FUNCT_W / `MEM_*  memory-stage load/store operation codes
`ifndef RISCV_DEFINES_SV
`define RISCV_DEFINES_SV

// Execute-stage ALU operations
`define EX_FUNCT_W 6
`define EX_ADD     6'b00_0001
`define EX_SUB     6'b00_0010
`define EX_AND     6'b00_0100
`define EX_OR      6'b00_1000
`define EX_XOR     6'b01_0000
`define EX_SLT     6'b10_0000

// Memory-stage operations
`define MEM_FUNCT_W 9
`define MEM_NOP    9'b0_0000_0001
`define MEM_LB     9'b0_0000_0010
`define MEM_LBU    9'b0_0000_0100
`define MEM_LH     9'b0_0000_1000
`define MEM_LHU    9'b0_0001_0000
`define MEM_LW     9'b0_0010_0000
`define MEM_SB     9'b0_0100_0000
`define MEM_SH     9'b0_1000_0000
`define MEM_SW     9'b1_0000_0000

`endif

// File: rtl/riscv_mem_lane.sv
// riscv_mem_lane
// Purely combinational byte-lane unit for the memory stage.
//   op_i       registered memory operation
//   addr_lo_i  low two bits of the byte address
//   st_data_i  store data (low byte / halfword significant for SB / SH)
//   rdata_i    captured bus read word
//   wmask_o    byte-lane write enables (0 for loads and NOP)
//   wdata_o    lane-replicated store data (0 for loads and NOP)
//   ld_data_o  selected and sign/zero-extended load result
// Halfwords are selected by addr_lo_i[1] only and words ignore addr_lo_i,
// so misaligned low bits behave as zero when no trap is configured.
`include "riscv_defines.sv"

module riscv_mem_lane
    import riscv_mem_ctrl_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Store side: replicate the datum on every lane so the bus only needs
    // the mask to know which bytes to commit.
    always_comb begin
        wmask_o = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (op_i)
            OP_SB: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            OP_SH: begin
                wmask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{st_data_i[15:0]}};
            end
            OP_SW: begin
                wmask_o = 4'b1111;
                wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        ldByte    = rdata_i[{addr_lo_i, 3'b000} +: 8];
        ldHalf    = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        ld_data_o = 32'h0000_0000;
        case (op_i)
            OP_LB:   ld_data_o = {{24{ldByte[7]}}, ldByte};
            OP_LBU:  ld_data_o = {24'h00_0000, ldByte};
            OP_LH:   ld_data_o = {{16{ldHalf[15]}}, ldHalf};
            OP_LHU:  ld_data_o = {16'h0000, ldHalf};
            OP_LW:   ld_data_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_mem_ctrl.sv
// riscv_mem_ctrl
// Memory-stage controller: accepts one load/store from execute, runs a
// single word-aligned bus transfer and, for loads, writes back one cycle.
//   clk, rstn              clock, asynchronous active-low reset
//   ex_mem_rdy/ack         request handshake (ack is high whenever idle)
//   ex_mem_funct/addr/data/rsd   one-hot op, byte address, store data, load dest
//   data_bif_*             bus: addr, req, rnw, wmask, wdata, rdata, ack
//   mem_wb_data/rsd/write  load writeback, valid for one cycle
//   mem_misalign           one-cycle misaligned-access pulse
// Build option: RISCV_MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses pulse mem_misalign and skip the bus; when not
// defined mem_misalign is tied low and the offending low bits are ignored.
`include "riscv_defines.sv"

module riscv_mem_ctrl
    import riscv_mem_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ex_mem_rdy,
    output logic                    ex_mem_ack,
    input  logic [`MEM_FUNCT_W-1:0] ex_mem_funct,
    input  logic [31:0]             ex_mem_addr,
    input  logic [31:0]             ex_mem_data,
    input  logic [4:0]              ex_mem_rsd,
    output logic [31:0]             data_bif_addr,
    output logic                    data_bif_req,
    output logic                    data_bif_rnw,
    output logic [3:0]              data_bif_wmask,
    output logic [31:0]             data_bif_wdata,
    input  logic [31:0]             data_bif_rdata,
    input  logic                    data_bif_ack,
    output logic [31:0]             mem_wb_data,
    output logic [4:0]              mem_wb_rsd,
    output logic                    mem_wb_write,
    output logic                    mem_misalign
);

    mem_state_e  state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rsd_q, rsd_d;
    logic [31:0] rdata_q, rdata_d;

    mem_op_e     reqOp;
    logic [3:0]  laneWmask;
    logic [31:0] laneWdata;
    logic [31:0] laneLdData;

    // State and transaction registers. Reset clears everything so the bus
    // and writeback outputs read as zero while rstn is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            rsd_q   <= 5'd0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rsd_q   <= rsd_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic. The transaction is captured only for a real
    // load/store, so an accepted NOP leaves every register untouched.
    // Bus ack is looked at only in BUS.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rsd_d   = rsd_q;
        rdata_d = rdata_q;
        reqOp   = decode_funct(ex_mem_funct);
        case (state_q)
            IDLE: begin
                if (ex_mem_rdy && (reqOp != OP_NOP)) begin
                    op_d   = reqOp;
                    addr_d = ex_mem_addr;
                    data_d = ex_mem_data;
                    rsd_d  = ex_mem_rsd;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
                    state_d = is_misaligned(reqOp, ex_mem_addr[1:0]) ? TRAP : BUS;
`else
                    state_d = BUS;
`endif
                end
            end
            BUS: begin
                if (data_bif_ack) begin
                    if (is_load(op_q)) begin
                        rdata_d = data_bif_rdata;
                        state_d = WB;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WB:      state_d = IDLE;
            TRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    riscv_mem_lane u_lane (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .st_data_i (data_q),
        .rdata_i   (rdata_q),
        .wmask_o   (laneWmask),
        .wdata_o   (laneWdata),
        .ld_data_o (laneLdData)
    );

    // All bus fields come from registers, so they stay constant for the
    // whole BUS period however long the ack takes.
    assign ex_mem_ack     = (state_q == IDLE);
    assign data_bif_req   = (state_q == BUS);
    assign data_bif_addr  = {addr_q[31:2], 2'b00};
    assign data_bif_rnw   = is_load(op_q);
    assign data_bif_wmask = (state_q == BUS) ? laneWmask : 4'b0000;
    assign data_bif_wdata = laneWdata;
    assign mem_wb_write   = (state_q == WB);
    assign mem_wb_data    = laneLdData;
    assign mem_wb_rsd     = rsd_q;

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    assign mem_misalign = (state_q == TRAP);
`else
    assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// tb_riscv_mem_ctrl
// Directed bench for riscv_mem_ctrl. A transaction-level model tracks what
// the controller must be doing from the handshakes it sees and a compare
// process checks the outputs against it every cycle; the directed sequences
// add hand-computed literal expectations on top.
`include "riscv_defines.sv"

module tb_riscv_mem_ctrl;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b1;
    logic                    ex_mem_rdy;
    logic                    ex_mem_ack;
    logic [`MEM_FUNCT_W-1:0] ex_mem_funct;
    logic [31:0]             ex_mem_addr;
    logic [31:0]             ex_mem_data;
    logic [4:0]              ex_mem_rsd;
    logic [31:0]             data_bif_addr;
    logic                    data_bif_req;
    logic                    data_bif_rnw;
    logic [3:0]              data_bif_wmask;
    logic [31:0]             data_bif_wdata;
    logic [31:0]             data_bif_rdata;
    logic                    data_bif_ack;
    logic [31:0]             mem_wb_data;
    logic [4:0]              mem_wb_rsd;
    logic                    mem_wb_write;
    logic                    mem_misalign;

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    int errCnt = 0;
    int checkCnt = 0;
    int cycleCnt = 0;

    // Snapshot of the bus fields seen in the first BUS cycle of a transfer.
    logic [31:0] busAddrSeen;
    logic [3:0]  busWmaskSeen;
    logic [31:0] busWdataSeen;
    logic        busRnwSeen;
    int          busAckHigh;

    // Transaction-level model state.
    bit                      mBusy = 1'b0;
    bit                      mWbDue = 1'b0;
    bit                      mTrapDue = 1'b0;
    logic [`MEM_FUNCT_W-1:0] mFunct;
    logic [31:0]             mAddr;
    logic [31:0]             mData;
    logic [4:0]              mRsd;
    logic [31:0]             mWbData;

    riscv_mem_ctrl dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_mem_rdy     (ex_mem_rdy),
        .ex_mem_ack     (ex_mem_ack),
        .ex_mem_funct   (ex_mem_funct),
        .ex_mem_addr    (ex_mem_addr),
        .ex_mem_data    (ex_mem_data),
        .ex_mem_rsd     (ex_mem_rsd),
        .data_bif_addr  (data_bif_addr),
        .data_bif_req   (data_bif_req),
        .data_bif_rnw   (data_bif_rnw),
        .data_bif_wmask (data_bif_wmask),
        .data_bif_wdata (data_bif_wdata),
        .data_bif_rdata (data_bif_rdata),
        .data_bif_ack   (data_bif_ack),
        .mem_wb_data    (mem_wb_data),
        .mem_wb_rsd     (mem_wb_rsd),
        .mem_wb_write   (mem_wb_write),
        .mem_misalign   (mem_misalign)
    );

    // 10-unit clock; cycle counter is read #1 after each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic bit isLoadF(input logic [`MEM_FUNCT_W-1:0] f);
        return (f == `MEM_LB) || (f == `MEM_LBU) || (f == `MEM_LH) ||
               (f == `MEM_LHU) || (f == `MEM_LW);
    endfunction

    function automatic bit isMemOpF(input logic [`MEM_FUNCT_W-1:0] f);
        return isLoadF(f) || (f == `MEM_SB) || (f == `MEM_SH) || (f == `MEM_SW);
    endfunction

    function automatic bit misalignedF(input logic [`MEM_FUNCT_W-1:0] f, input logic [31:0] a);
        if ((f == `MEM_LH) || (f == `MEM_LHU) || (f == `MEM_SH)) return (a % 2) != 0;
        if ((f == `MEM_LW) || (f == `MEM_SW)) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] expWmask(input logic [`MEM_FUNCT_W-1:0] f, input logic [31:0] a);
        if (f == `MEM_SB) return 32'(1) << (a % 4);
        if (f == `MEM_SH) return 32'(3) << (a & 32'd2);
        if (f == `MEM_SW) return 32'hF;
        return 32'h0;
    endfunction

    function automatic logic [31:0] expWdata(input logic [`MEM_FUNCT_W-1:0] f, input logic [31:0] d);
        if (f == `MEM_SB) return (d & 32'hFF) * 32'h0101_0101;
        if (f == `MEM_SH) return (d & 32'hFFFF) * 32'h0001_0001;
        if (f == `MEM_SW) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] loadValue(input logic [`MEM_FUNCT_W-1:0] f,
                                              input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f == `MEM_LB)  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
        if (f == `MEM_LBU) return b;
        if (f == `MEM_LH)  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
        if (f == `MEM_LHU) return h;
        return rd;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: at most one transaction outstanding; a load owes one writeback
    // cycle after its ack, a trapped access owes one misalign cycle.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mBusy    <= 1'b0;
            mWbDue   <= 1'b0;
            mTrapDue <= 1'b0;
        end else if (mWbDue || mTrapDue) begin
            mWbDue   <= 1'b0;
            mTrapDue <= 1'b0;
        end else if (mBusy) begin
            if (data_bif_ack) begin
                mBusy <= 1'b0;
                if (isLoadF(mFunct)) begin
                    mWbDue  <= 1'b1;
                    mWbData <= loadValue(mFunct, mAddr, data_bif_rdata);
                end
            end
        end else if (ex_mem_rdy && isMemOpF(ex_mem_funct)) begin
            mFunct <= ex_mem_funct;
            mAddr  <= ex_mem_addr;
            mData  <= ex_mem_data;
            mRsd   <= ex_mem_rsd;
            if (TrapEn && misalignedF(ex_mem_funct, ex_mem_addr)) mTrapDue <= 1'b1;
            else mBusy <= 1'b1;
        end
    end

    // Per-cycle compare on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        checkOutput("cycAck", 32'(ex_mem_ack), 32'(!(mBusy || mWbDue || mTrapDue)));
        checkOutput("cycReq", 32'(data_bif_req), 32'(mBusy));
        checkOutput("cycWrite", 32'(mem_wb_write), 32'(mWbDue));
        checkOutput("cycMisalign", 32'(mem_misalign), 32'(mTrapDue));
        if (mBusy) begin
            checkOutput("cycAddr", data_bif_addr, mAddr & 32'hFFFF_FFFC);
            checkOutput("cycRnw", 32'(data_bif_rnw), 32'(isLoadF(mFunct)));
            checkOutput("cycWmask", 32'(data_bif_wmask), expWmask(mFunct, mAddr));
            checkOutput("cycWdata", data_bif_wdata, expWdata(mFunct, mData));
        end
        if (mWbDue) begin
            checkOutput("cycWbData", mem_wb_data, mWbData);
            checkOutput("cycWbRsd", 32'(mem_wb_rsd), 32'(mRsd));
        end
    end

    // Present one request, wait (bounded) for acceptance, then act as the
    // bus: ack after ackDelay extra cycles. ackDelay < 0 means no bus phase.
    task automatic applyStimulus(input logic [`MEM_FUNCT_W-1:0] funct, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] rsd,
                                 input int ackDelay, input logic [31:0] rdata,
                                 output int acceptCycle, output int reqCycles);
        bit accepted;
        int waitCnt;
        accepted    = 1'b0;
        waitCnt     = 0;
        reqCycles   = 0;
        acceptCycle = -1;
        busAckHigh  = 0;
        ex_mem_rdy   = 1'b1;
        ex_mem_funct = funct;
        ex_mem_addr  = addr;
        ex_mem_data  = data;
        ex_mem_rsd   = rsd;
        while (!accepted && waitCnt < 20) begin
            @(negedge clk);
            accepted = ex_mem_ack;
            @(posedge clk);
            #1;
            waitCnt++;
        end
        ex_mem_rdy   = 1'b0;
        ex_mem_funct = `MEM_NOP;
        if (!accepted) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            return;
        end
        acceptCycle = cycleCnt;
        if (ackDelay < 0) return;
        for (int k = 0; k <= ackDelay; k++) begin
            data_bif_ack   = (k == ackDelay);
            data_bif_rdata = (k == ackDelay) ? rdata : (32'hBAD0_0000 | 32'(k));
            @(negedge clk);
            if (k == 0) begin
                busAddrSeen  = data_bif_addr;
                busWmaskSeen = data_bif_wmask;
                busWdataSeen = data_bif_wdata;
                busRnwSeen   = data_bif_rnw;
            end
            if (data_bif_req) reqCycles++;
            if (ex_mem_ack) busAckHigh++;
            @(posedge clk);
            #1;
        end
        data_bif_ack = 1'b0;
    endtask

    // Expect exactly one writeback cycle right now, then none.
    task automatic expectWriteback(input string name, input logic [31:0] data, input logic [4:0] rsd);
        @(negedge clk);
        checkOutput({name, "Write"}, 32'(mem_wb_write), 32'd1);
        checkOutput({name, "Data"}, mem_wb_data, data);
        checkOutput({name, "Rsd"}, 32'(mem_wb_rsd), 32'(rsd));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({name, "OneShot"}, 32'(mem_wb_write), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int acc1, acc2, reqN;
        ex_mem_rdy     = 1'b0;
        ex_mem_funct   = `MEM_NOP;
        ex_mem_addr    = 32'h0;
        ex_mem_data    = 32'h0;
        ex_mem_rsd     = 5'd0;
        data_bif_ack   = 1'b0;
        data_bif_rdata = 32'h0;

        // Reset with noise on the inputs; everything must stay quiet.
        #1 rstn = 1'b0;
        ex_mem_rdy   = 1'b1;
        ex_mem_funct = `MEM_LW;
        ex_mem_addr  = 32'h1234;
        data_bif_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReq", 32'(data_bif_req), 32'd0);
        checkOutput("rstWrite", 32'(mem_wb_write), 32'd0);
        checkOutput("rstMisalign", 32'(mem_misalign), 32'd0);
        checkOutput("rstWmask", 32'(data_bif_wmask), 32'd0);
        checkOutput("rstAddr", data_bif_addr, 32'd0);
        checkOutput("rstWdata", data_bif_wdata, 32'd0);
        checkOutput("rstWbData", mem_wb_data, 32'd0);
        checkOutput("rstWbRsd", 32'(mem_wb_rsd), 32'd0);
        @(posedge clk);
        #1;
        ex_mem_rdy   = 1'b0;
        ex_mem_funct = `MEM_NOP;
        data_bif_ack = 1'b0;
        rstn         = 1'b1;
        @(negedge clk);
        checkOutput("ackAfterRst", 32'(ex_mem_ack), 32'd1);
        @(posedge clk);
        #1;

        // SB 0x103 / 0xA5: top lane, byte replicated, no writeback.
        applyStimulus(`MEM_SB, 32'h103, 32'h0000_00A5, 5'd3, 2, 32'h0, acc1, reqN);
        checkOutput("sbAddr", busAddrSeen, 32'h100);
        checkOutput("sbWmask", 32'(busWmaskSeen), 32'h8);
        checkOutput("sbWdata", busWdataSeen, 32'hA5A5_A5A5);
        checkOutput("sbRnw", 32'(busRnwSeen), 32'd0);
        checkOutput("sbReqCycles", 32'(reqN), 32'd3);
        @(negedge clk);
        checkOutput("sbNoWb", 32'(mem_wb_write), 32'd0);
        @(posedge clk);
        #1;

        // LB / LBU at 0x102 with lane 2 = 0x80.
        applyStimulus(`MEM_LB, 32'h102, 32'h0, 5'd7, 1, 32'h0080_0000, acc1, reqN);
        checkOutput("lbRnw", 32'(busRnwSeen), 32'd1);
        checkOutput("lbWmask", 32'(busWmaskSeen), 32'd0);
        expectWriteback("lb", 32'hFFFF_FF80, 5'd7);
        applyStimulus(`MEM_LBU, 32'h102, 32'h0, 5'd7, 1, 32'h0080_0000, acc1, reqN);
        expectWriteback("lbu", 32'h0000_0080, 5'd7);

        // LH 0x002 with a slow bus: req held 6 cycles, no ex ack meanwhile.
        applyStimulus(`MEM_LH, 32'h002, 32'h0, 5'd12, 5, 32'h8001_1234, acc1, reqN);
        checkOutput("lhReqCycles", 32'(reqN), 32'd6);
        checkOutput("lhExAckDuringBus", 32'(busAckHigh), 32'd0);
        checkOutput("lhAddr", busAddrSeen, 32'h0);
        expectWriteback("lh", 32'hFFFF_8001, 5'd12);

        // Back-to-back SW then LW with zero-wait bus.
        applyStimulus(`MEM_SW, 32'h200, 32'hDEAD_BEEF, 5'd0, 0, 32'h0, acc1, reqN);
        checkOutput("swAddr", busAddrSeen, 32'h200);
        checkOutput("swWmask", 32'(busWmaskSeen), 32'hF);
        checkOutput("swWdata", busWdataSeen, 32'hDEAD_BEEF);
        checkOutput("swReqCycles", 32'(reqN), 32'd1);
        applyStimulus(`MEM_LW, 32'h200, 32'h0, 5'd9, 0, 32'hDEAD_BEEF, acc2, reqN);
        checkOutput("b2bAcceptGap", 32'(acc2 - acc1), 32'd2);
        expectWriteback("lw", 32'hDEAD_BEEF, 5'd9);

        // SH upper half, LHU upper half, LB positive byte.
        applyStimulus(`MEM_SH, 32'h0FE, 32'h1234_ABCD, 5'd0, 1, 32'h0, acc1, reqN);
        checkOutput("shAddr", busAddrSeen, 32'hFC);
        checkOutput("shWmask", 32'(busWmaskSeen), 32'hC);
        checkOutput("shWdata", busWdataSeen, 32'hABCD_ABCD);
        applyStimulus(`MEM_LHU, 32'h106, 32'h0, 5'd31, 0, 32'h8001_7FFF, acc1, reqN);
        expectWriteback("lhu", 32'h0000_8001, 5'd31);
        applyStimulus(`MEM_LB, 32'h101, 32'h0, 5'd1, 2, 32'h0000_7F00, acc1, reqN);
        expectWriteback("lbPos", 32'h0000_007F, 5'd1);

        // NOP and a multi-hot code: accepted, nothing happens.
        applyStimulus(`MEM_NOP, 32'h40, 32'h0, 5'd2, -1, 32'h0, acc1, reqN);
        @(negedge clk);
        checkOutput("nopReq", 32'(data_bif_req), 32'd0);
        checkOutput("nopIdle", 32'(ex_mem_ack), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(9'b0_0000_0110, 32'h44, 32'h0, 5'd2, -1, 32'h0, acc1, reqN);
        @(negedge clk);
        checkOutput("badFunctReq", 32'(data_bif_req), 32'd0);
        checkOutput("badFunctIdle", 32'(ex_mem_ack), 32'd1);
        @(posedge clk);
        #1;

        // Bus ack while idle must be ignored.
        data_bif_ack   = 1'b1;
        data_bif_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("strayAckWrite", 32'(mem_wb_write), 32'd0);
            checkOutput("strayAckReq", 32'(data_bif_req), 32'd0);
            @(posedge clk);
            #1;
        end
        data_bif_ack = 1'b0;

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
        // Misaligned LW traps: pulse at N+1, no bus, idle at N+2.
        applyStimulus(`MEM_LW, 32'h201, 32'h0, 5'd4, -1, 32'h0, acc1, reqN);
        @(negedge clk);
        checkOutput("trapPulse", 32'(mem_misalign), 32'd1);
        checkOutput("trapNoReq", 32'(data_bif_req), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("trapPulseEnd", 32'(mem_misalign), 32'd0);
        checkOutput("trapIdle", 32'(ex_mem_ack), 32'd1);
        checkOutput("trapStillNoReq", 32'(data_bif_req), 32'd0);
        @(posedge clk);
        #1;
`else
        // Misaligned accesses proceed with the low bits treated as zero.
        applyStimulus(`MEM_LW, 32'h201, 32'h0, 5'd4, 0, 32'h1122_3344, acc1, reqN);
        checkOutput("misLwAddr", busAddrSeen, 32'h200);
        expectWriteback("misLw", 32'h1122_3344, 5'd4);
        applyStimulus(`MEM_SH, 32'h103, 32'h0000_5A3C, 5'd0, 0, 32'h0, acc1, reqN);
        checkOutput("misShWmask", 32'(busWmaskSeen), 32'hC);
        checkOutput("misShWdata", busWdataSeen, 32'h5A3C_5A3C);
`endif

        // Reset during BUS: req drops at once, a later ack is ignored.
        applyStimulus(`MEM_LW, 32'h300, 32'h0, 5'd5, -1, 32'h0, acc1, reqN);
        #2;
        checkOutput("rmbReqBefore", 32'(data_bif_req), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("rmbReqDrop", 32'(data_bif_req), 32'd0);
        @(posedge clk);
        #1;
        rstn           = 1'b1;
        data_bif_ack   = 1'b1;
        data_bif_rdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        data_bif_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rmbNoWb", 32'(mem_wb_write), 32'd0);
            checkOutput("rmbIdle", 32'(ex_mem_ack), 32'd1);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule
